// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: LCD pixel fetch, writer port, frame pacing.
// Define FB_ARB_CLEAR_EN to build the framebuffer clear engine.
module fb_arbiter #(
  parameter int unsigned FRAME_DIV   = 800000,
  parameter int unsigned FB_BYTES    = 1920,
  parameter logic [7:0]  CLEAR_VALUE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  lcd_x,
  input  logic [2:0]  lcd_y,
  output logic [7:0]  lcd_pixels,
  output logic        frame_strobe,
  input  logic [10:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [10:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  input  logic        clear_req,
  output logic        clear_busy
);

  typedef enum logic [1:0] {
    IDLE, RD_ADDR, RD_DATA, WR
  } state_t;

  localparam int CW = $clog2(FRAME_DIV);
  localparam logic [10:0] FB_END = 11'(FB_BYTES);

  state_t      state, state_d;
  logic [10:0] key, lcd_addr;
  logic [10:0] cache_key, cache_key_d;
  logic [10:0] cache_addr, cache_addr_d;
  logic        cache_valid, cache_valid_d;
  logic [7:0]  pix_d, wdata_d;
  logic [10:0] addr_d;
  logic        we_d;
  logic        read_needed, blank, fire, busy;
  logic [CW-1:0] cnt;
  logic [7:0]  prev_x;

  assign key      = {lcd_y, lcd_x};
  assign lcd_addr = {lcd_y, 8'd0} - {4'd0, lcd_y, 4'd0}
                  + {3'd0, lcd_x};
  assign blank    = lcd_x >= 8'd240;
  assign read_needed = !cache_valid || (key != cache_key);
  assign wr_ready = (state == IDLE) && !read_needed && !busy;
  assign fire     = wr_valid && wr_ready;

`ifdef FB_ARB_CLEAR_EN
  localparam logic [10:0] LAST = 11'(FB_BYTES - 1);
  logic        busy_d, clr_wr, clr_wr_d;
  logic [10:0] clr_addr, clr_addr_d;
  assign clear_busy = busy;
`else
  logic unused_ok;
  assign busy       = 1'b0;
  assign clear_busy = 1'b0;
  assign unused_ok  = clear_req | (|CLEAR_VALUE);
`endif

  always_comb begin
    state_d       = state;
    cache_key_d   = cache_key;
    cache_addr_d  = cache_addr;
    cache_valid_d = cache_valid;
    pix_d         = lcd_pixels;
    addr_d        = ram_addr;
    wdata_d       = ram_wdata;
    we_d          = 1'b0;
`ifdef FB_ARB_CLEAR_EN
    busy_d     = busy;
    clr_addr_d = clr_addr;
    clr_wr_d   = 1'b0;
    if (clear_req && !busy) begin
      busy_d     = 1'b1;
      clr_addr_d = '0;
    end
`endif
    unique case (state)
      IDLE: begin
        if (read_needed) begin
          cache_key_d  = key;
          cache_addr_d = lcd_addr;
          if (blank) begin
            pix_d         = '0;
            cache_valid_d = 1'b1;
          end else begin
            addr_d  = lcd_addr;
            state_d = RD_ADDR;
          end
        end else if (fire) begin
          addr_d  = wr_addr;
          wdata_d = wr_data;
          we_d    = wr_addr < FB_END;
          state_d = WR;
          if (wr_addr == cache_addr) cache_valid_d = 1'b0;
        end
`ifdef FB_ARB_CLEAR_EN
        else if (busy) begin
          addr_d   = clr_addr;
          wdata_d  = CLEAR_VALUE;
          we_d     = 1'b1;
          clr_wr_d = 1'b1;
          state_d  = WR;
        end
`endif
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        pix_d         = ram_rdata;
        cache_valid_d = 1'b1;
        state_d       = IDLE;
      end
      WR: begin
        state_d = IDLE;
`ifdef FB_ARB_CLEAR_EN
        // only a clear-issued write advances the fill pointer
        if (clr_wr) begin
          if (clr_addr == LAST) begin
            busy_d        = 1'b0;
            cache_valid_d = 1'b0;
          end else begin
            clr_addr_d = clr_addr + 11'd1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cache_key   <= '0;
      cache_addr  <= '0;
      cache_valid <= 1'b0;
      lcd_pixels  <= '0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
    end else begin
      state       <= state_d;
      cache_key   <= cache_key_d;
      cache_addr  <= cache_addr_d;
      cache_valid <= cache_valid_d;
      lcd_pixels  <= pix_d;
      ram_addr    <= addr_d;
      ram_we      <= we_d;
      ram_wdata   <= wdata_d;
    end
  end

`ifdef FB_ARB_CLEAR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      clr_addr <= '0;
      clr_wr   <= 1'b0;
    end else begin
      busy     <= busy_d;
      clr_addr <= clr_addr_d;
      clr_wr   <= clr_wr_d;
    end
  end
`endif

  // strobe clears once the driver leaves column 0 on page 0
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      frame_strobe <= 1'b0;
      prev_x       <= '0;
    end else begin
      prev_x <= lcd_x;
      if (cnt == CW'(FRAME_DIV - 1)) begin
        cnt          <= '0;
        frame_strobe <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
        if (lcd_y == 3'd0 && prev_x == 8'd0 && lcd_x != 8'd0)
          frame_strobe <= 1'b0;
      end
    end
  end

endmodule
